// File: rtl/nihilist_pkg.sv
// Shared constants for the Nihilist stream codec: the Polybius square,
// beat modes and FSM state encodings.
package nihilist_pkg;

    // Row-major 5x5 square; index 0 is row 1 col 1 ('D').
    localparam logic [0:24][7:0] SQUARE      = "DANIELBCFGHKMOPQRSTUVWXYZ";
    localparam logic             MODE_ENC    = 1'b0;
    localparam logic             MODE_DEC    = 1'b1;
    localparam logic [7:0]       POS_INVALID = 8'd0;

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    // Square index -> row*10+col code.
    function automatic logic [7:0] sq_pos(input int i);
        return 8'((i / 5 + 1) * 10 + i % 5 + 1);
    endfunction

endpackage

// File: rtl/polybius_lookup.sv
// Combinational Polybius lookup: letter -> position and position -> letter.
module polybius_lookup
    import nihilist_pkg::*;
(
    input  logic [7:0] char_i,
    input  logic [7:0] pos_i,
    output logic [7:0] pos_o,
    output logic       found_o,
    output logic [7:0] letter_o,
    output logic       valid_o
);

    logic [7:0] upper;

    always_comb begin
        upper    = (char_i >= "a" && char_i <= "z") ? char_i - 8'd32 : char_i;
        pos_o    = POS_INVALID;
        found_o  = 1'b0;
        letter_o = 8'd0;
        valid_o  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (upper == SQUARE[i]) begin
                pos_o   = sq_pos(i);
                found_o = 1'b1;
            end
            if (pos_i == sq_pos(i)) begin
                letter_o = SQUARE[i];
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nihilist_stream_codec.sv
// Byte-serial Nihilist encrypt/decrypt engine with a runtime-loadable
// repeating key; one-cycle latency, full throughput valid/ready streams.
module nihilist_stream_codec
    import nihilist_pkg::*;
#(
    parameter int P_KEY_MAX_LEN = 16,
    parameter int P_KEY_IDX_W   = $clog2(P_KEY_MAX_LEN)
) (
    input  logic       i_w_clk,
    input  logic       i_w_rst_n,
    input  logic       i_w_key_valid,
    input  logic [7:0] i_w_key_byte,
    input  logic       i_w_key_last,
    output logic       o_r_key_ready,
    output logic       o_r_key_loaded,
    output logic       o_r_err_overflow,
    input  logic       i_w_in_valid,
    input  logic [7:0] i_w_in_byte,
    input  logic       i_w_in_mode,
    input  logic       i_w_in_last,
    output logic       o_w_in_ready,
    output logic       o_r_out_valid,
    output logic [7:0] o_r_out_byte,
    output logic       o_r_out_last,
    input  logic       i_w_out_ready
);

    // Length needs one extra bit so it can hold P_KEY_MAX_LEN itself.
    localparam int LEN_W = P_KEY_IDX_W + 1;

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [P_KEY_IDX_W-1:0] idx_q, idx_d;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    logic                   out_valid_q, out_last_q;
    logic [7:0]             out_byte_q;
    logic [7:0]             key_mem_q [P_KEY_MAX_LEN];

    logic                   key_wr;
    logic [P_KEY_IDX_W-1:0] key_waddr;
    logic                   key_acc, in_acc;

    logic [7:0] key_char, k, dat_pos, dec_d, dec_letter, enc_res, dec_res, res;
    logic       dat_found, dec_valid;
    logic [7:0] key_rev_letter;
    logic       key_found, key_rev_valid;

    assign o_r_key_ready    = (state_q == S_RUN) ? !out_valid_q : 1'b1;
    assign o_w_in_ready     = (state_q == S_RUN) && loaded_q &&
                              (!out_valid_q || i_w_out_ready) && !i_w_key_valid;
    assign key_acc          = i_w_key_valid && o_r_key_ready;
    assign in_acc           = i_w_in_valid && o_w_in_ready;
    assign o_r_key_loaded   = loaded_q;
    assign o_r_err_overflow = err_q;
    assign o_r_out_valid    = out_valid_q;
    assign o_r_out_byte     = out_byte_q;
    assign o_r_out_last     = out_last_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        key_wr    = 1'b0;
        key_waddr = '0;
        case (state_q)
            S_LOAD: begin
                if (key_acc) begin
                    if (len_q == LEN_W'(P_KEY_MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        key_wr    = 1'b1;
                        key_waddr = len_q[P_KEY_IDX_W-1:0];
                        len_d     = len_q + 1'b1;
                    end
                    if (i_w_key_last) begin
                        state_d  = S_RUN;
                        loaded_d = 1'b1;
                        idx_d    = '0;
                    end
                end
            end
            S_NOKEY, S_RUN: begin
                // A key byte in S_RUN throws away the old key and restarts loading.
                if (key_acc) begin
                    key_wr   = 1'b1;
                    len_d    = LEN_W'(1);
                    idx_d    = '0;
                    loaded_d = i_w_key_last;
                    state_d  = i_w_key_last ? S_RUN : S_LOAD;
                end else if (in_acc) begin
                    idx_d = (i_w_in_last || ({1'b0, idx_q} == len_q - 1'b1)) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = S_NOKEY;
        endcase
    end

    assign key_char = key_mem_q[idx_q];

    polybius_lookup u_key_lookup (
        .char_i   (key_char),
        .pos_i    (POS_INVALID),
        .pos_o    (k),
        .found_o  (key_found),
        .letter_o (key_rev_letter),
        .valid_o  (key_rev_valid)
    );

    assign dec_d = i_w_in_byte - k;

    polybius_lookup u_dat_lookup (
        .char_i   (i_w_in_byte),
        .pos_i    (dec_d),
        .pos_o    (dat_pos),
        .found_o  (dat_found),
        .letter_o (dec_letter),
        .valid_o  (dec_valid)
    );

    // Bytes outside the square are encrypted from their raw value.
    assign enc_res = (dat_found ? dat_pos : i_w_in_byte) + k;
    assign dec_res = dec_valid ? dec_letter : dec_d;
    assign res     = (i_w_in_mode == MODE_DEC) ? dec_res : enc_res;

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            state_q     <= S_NOKEY;
            len_q       <= '0;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            if (in_acc) begin
                out_valid_q <= 1'b1;
                out_byte_q  <= res;
                out_last_q  <= i_w_in_last;
            end else if (i_w_out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (key_wr) key_mem_q[key_waddr] <= i_w_key_byte;
    end

endmodule

// File: tb/tb_nihilist_stream_codec.sv
// Randomised self-checking bench for nihilist_stream_codec against a
// string/queue based cipher model.
module tb_nihilist_stream_codec;

    localparam int KMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0, key_last = 1'b0;
    logic [7:0] key_byte = 8'd0;
    logic       key_ready, key_loaded, err;
    logic       in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0;
    logic [7:0] in_byte = 8'd0;
    logic       in_ready;
    logic       out_valid, out_last;
    logic [7:0] out_byte;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    nihilist_stream_codec #(.P_KEY_MAX_LEN(KMAX)) dut (
        .i_w_clk          (clk),
        .i_w_rst_n        (rst_n),
        .i_w_key_valid    (key_valid),
        .i_w_key_byte     (key_byte),
        .i_w_key_last     (key_last),
        .o_r_key_ready    (key_ready),
        .o_r_key_loaded   (key_loaded),
        .o_r_err_overflow (err),
        .i_w_in_valid     (in_valid),
        .i_w_in_byte      (in_byte),
        .i_w_in_mode      (in_mode),
        .i_w_in_last      (in_last),
        .o_w_in_ready     (in_ready),
        .o_r_out_valid    (out_valid),
        .o_r_out_byte     (out_byte),
        .o_r_out_last     (out_last),
        .i_w_out_ready    (out_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    string        SQ = "DANIELBCFGHKMOPQRSTUVWXYZ";
    logic [7:0]   mkey[$];
    bit           mnew = 1'b1;
    bit           merr = 1'b0;
    int           midx = 0;
    logic [8:0]   exq[$];

    function automatic int sq_index(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'd97 && c <= 8'd122) ? c - 8'd32 : c;
        for (int i = 0; i < 25; i++) if (SQ[i] == u) return i;
        return -1;
    endfunction

    function automatic logic [7:0] pos_of(input int i);
        return 8'((i / 5 + 1) * 10 + (i % 5) + 1);
    endfunction

    function automatic logic [7:0] ref_beat(input logic [7:0] b, input bit mode);
        int ki, bi, r, c;
        logic [7:0] k, t, d;
        ki = sq_index(mkey[midx]);
        k  = (ki < 0) ? 8'd0 : pos_of(ki);
        if (!mode) begin
            bi = sq_index(b);
            t  = (bi < 0) ? b : pos_of(bi);
            return t + k;
        end
        d = b - k;
        r = int'(d) / 10;
        c = int'(d) % 10;
        if (r >= 1 && r <= 5 && c >= 1 && c <= 5) return 8'(SQ[(r - 1) * 5 + c - 1]);
        return d;
    endfunction

    // Scoreboard: every completed output transfer must match the model queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exq.size() == 0) begin
                chk("unexpected_out", exq.size(), 1);
            end else begin
                logic [8:0] e;
                e = exq.pop_front();
                chk("out_byte", {24'd0, out_byte}, {24'd0, e[7:0]});
                chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
            end
        end
    end

    bit rnd_en = 1'b0;
    always @(posedge clk) begin
        if (rnd_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit mode, input bit last);
        bit done = 1'b0;
        in_byte  = b;
        in_mode  = mode;
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exq.push_back({last, ref_beat(b, mode)});
                midx = last ? 0 : (midx + 1) % mkey.size();
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("in_timeout", {31'd0, done}, 1);
    endtask

    task automatic send_key(input logic [7:0] b, input bit last);
        bit done = 1'b0;
        key_byte  = b;
        key_last  = last;
        key_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (key_ready) begin
                if (mnew) begin mkey.delete(); mnew = 1'b0; end
                if (mkey.size() < KMAX) mkey.push_back(b); else merr = 1'b1;
                if (last) begin mnew = 1'b1; midx = 0; end
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        key_valid = 1'b0;
        if (!done) chk("key_timeout", {31'd0, done}, 1);
    endtask

    task automatic load_key(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_key(8'(s[i]), i == s.len() - 1);
            if (i != s.len() - 1) chk("loading", {31'd0, key_loaded}, 0);
        end
        chk("key_loaded", {31'd0, key_loaded}, 1);
        chk("err_overflow", {31'd0, err}, {31'd0, merr});
    endtask

    task automatic send_msg(input string s, input bit mode);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), mode, i == s.len() - 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (exq.size() != 0 || out_valid); n++) @(posedge clk);
        #1;
        chk("drain", exq.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exq.delete();
        mkey.delete();
        mnew = 1'b1;
        merr = 1'b0;
        midx = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_key_loaded", {31'd0, key_loaded}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_key_ready", {31'd0, key_ready}, 1);
        rst_n = 1'b1;

        // Data offered with no key loaded must be held off.
        in_valid = 1'b1; in_byte = "H";
        repeat (4) begin
            @(negedge clk);
            chk("nokey_in_ready", {31'd0, in_ready}, 0);
            chk("nokey_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        load_key("AB");
        send_msg("HI", 1'b0);
        send_byte(8'd43, 1'b1, 1'b0);
        send_byte(8'd36, 1'b1, 1'b1);
        send_byte(8'd46, 1'b1, 1'b1);
        drain();

        load_key("A");
        send_msg("Dd.", 1'b0);
        send_byte(8'd58, 1'b1, 1'b1);
        drain();

        // Backpressure: output must hold and input must stall.
        load_key("AB");
        send_byte("H", 1'b0, 1'b0);
        out_ready = 1'b0;
        in_byte = "I"; in_mode = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            chk("bp_out_valid", {31'd0, out_valid}, 1);
            chk("bp_out_byte", {24'd0, out_byte}, {24'd0, exq[0][7:0]});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_byte("I", 1'b0, 1'b1);
        drain();

        load_key("ABCDEF");
        send_msg("DDDDD", 1'b0);
        drain();

        // Randomised traffic with random sink backpressure.
        rnd_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            if (it % 5 == 0) begin
                string ks;
                int kl;
                ks = "";
                kl = $urandom_range(1, 6);
                for (int j = 0; j < kl; j++) begin
                    case ($urandom_range(0, 3))
                        0, 1:    ks = {ks, string'(8'(65 + $urandom_range(0, 25)))};
                        2:       ks = {ks, string'(8'(97 + $urandom_range(0, 25)))};
                        default: ks = {ks, string'(8'($urandom_range(32, 126)))};
                    endcase
                end
                load_key(ks);
            end
            begin
                int ml;
                bit md;
                ml = $urandom_range(1, 6);
                for (int j = 0; j < ml; j++) begin
                    md = $urandom_range(0, 1);
                    send_byte(md ? 8'($urandom_range(0, 120)) :
                              ($urandom_range(0, 2) != 0 ? 8'(65 + $urandom_range(0, 25))
                                                         : 8'($urandom_range(0, 255))),
                              md, j == ml - 1);
                end
            end
        end
        rnd_en = 1'b0;
        #1 out_ready = 1'b1;
        drain();

        // Reset mid-stream: in-flight output and key are discarded.
        out_ready = 1'b0;
        send_byte("A", 1'b0, 1'b0);
        in_byte = "B"; in_valid = 1'b1;
        @(posedge clk); #1;
        do_reset();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_key_loaded", {31'd0, key_loaded}, 0);
        chk("mid_rst_err", {31'd0, err}, 0);
        chk("mid_rst_key_ready", {31'd0, key_ready}, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_in_ready", {31'd0, in_ready}, 0);
            chk("post_rst_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
